pair_merge_fifo: RTL
====================

# pair_merge_fifo

- Write-side counterpart of the duplicate FIFO: every stored entry is assembled from **two** consecutive accepted pushes and removed by **one** pop.
- Sits between a DW-bit producer and a 2·DW-bit consumer, so narrow beats reach a wide datapath without an external gearbox.
- First push supplies the low half and is held in a staging register; the second push supplies the high half and commits `{high, low}` into a circular buffer.

## Interface
- DW, 16: width of one pushed half-word (bits).
- DEPTH, 4: number of 2·DW entries; any value ≥ 2, not required to be a power of two.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- write_data  in  DW  half-word to push.
- push  in  1  write request.
- full  out  1  high when DEPTH committed entries are held.
- half_pending  out  1  high when a low half is staged and awaiting its high half.
- read_data  out  2·DW  head entry, `{high, low}`; first-word fall-through.
- empty  out  1  high when no committed entry is held.
- pop  in  1  read request; removes the head entry.
- flush  in  1  present only with HALF_FLUSH_EN (see Configuration).

## Operation
- **Derived signals**
  - push_acc = push && (!full || pop).
  - pop_acc = pop && !empty.
  - A push while full is accepted only together with a same-cycle pop.
- **Staging FSM**, two states, reset state LOW:
  - LOW: on push_acc, capture write_data into lo_q and go to HIGH. Nothing is committed.
  - HIGH: on push_acc, write `{write_data, lo_q}` into mem[tail], advance tail and go to LOW.
  - half_pending = (state == HIGH).
- **Pointers**
  - head and tail are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
  - tail advances only on a commit.
  - head advances on pop_acc.
- **Entry counter**
  - Binary count, $clog2(DEPTH+1) bits wide.
  - +1 on commit without pop_acc; −1 on pop_acc without commit; unchanged when both or neither occur.
  - empty = (count == 0); full = (count == DEPTH).
- **Rejected requests**
  - Pop while empty: ignored, no state change.
  - Push while full without pop: ignored. The staging state is preserved, including a pending low half.
- **Combinational output**: read_data = mem[head].

## Timing
- **Reset** (async on rst = 0):
  - head = tail = count = 0; state = LOW; lo_q = 0; mem cleared to 0.
  - Outputs: empty = 1, full = 0, half_pending = 0, read_data = 0.
- **Latency**
  - A second-half push at edge N makes the entry visible on read_data, and deasserts empty, after edge N.
  - A first-half push alone never changes empty or full.
- **Simultaneous events**
  - Commit and pop in the same cycle with count = DEPTH: both take effect, and full stays high.
  - Commit and pop in the same cycle with count = 1: the new entry appears at the next head, and empty stays low.
  - A first-half push while full and popping: accepted, count drops by 1.
- **Reset mid-operation**: any staged low half is discarded, with no partial commit.

## Configuration
- **HALF_FLUSH_EN defined**
  - The `flush` input exists.
  - In HIGH, with flush = 1, push = 0, and room available (!full || pop_acc), commit `{DW'b0, lo_q}` and return to LOW.
  - A push in the same cycle takes precedence over flush; flush is then ignored for that cycle.
  - In LOW, flush has no effect.
- **HALF_FLUSH_EN undefined**
  - No `flush` port.
  - A low half can leave staging only by pairing with a second push, or by reset.

## Structure
- Package `pair_fifo_pkg`: function `ptr_w(depth)` returning $clog2(depth), and the staging-state enum `stage_e {ST_LOW, ST_HIGH}`.
- Sub-module `pair_stage`:
  - Contains the staging FSM, lo_q and the optional flush logic.
  - Inputs: push_acc, write_data, flush.
  - Outputs: commit, commit_data[2·DW-1:0], half_pending.
- Top level: pointers, entry counter, memory and flags.

## Test plan
- After reset release: empty = 1, full = 0, half_pending = 0, read_data = 0.
- Push 16'h1111 then 16'h2222:
  - half_pending = 1 after the first push.
  - After the second push: empty = 0 and read_data = 32'h2222_1111.
  - Pop → empty = 1.
- Fill with 8 pushes (DEPTH = 4) → full = 1.
  - A 9th push alone is ignored; count stays 4 and half_pending stays 0.
  - A push with pop while full is accepted, half_pending = 1, and the head entry changes.
- Wrap-around: 12 push pairs interleaved with pops; popped data must match the commit order exactly across the tail/head wrap.
- Push 16'hAAAA, assert rst for one cycle, then push 16'hBBBB and 16'hCCCC → a single entry equal to 32'hCCCC_BBBB.
- HALF_FLUSH_EN build: push 16'h00FF, then flush = 1 with push = 0 → read_data = 32'h0000_00FF, half_pending = 0.
  - Flush together with push 16'h1234 → entry 32'h1234_00FF.

Source files
------------

// File: rtl/pair_merge_fifo_pkg.sv
// Shared types and helpers for pair_merge_fifo: pointer-width helper and
// the staging-state enum used by the half-word staging FSM.
package pair_fifo_pkg;

  typedef enum logic {ST_LOW, ST_HIGH} stage_e;

  // Width of a circular-buffer pointer for a given depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pair_merge_fifo_stage.sv
// pair_stage: holds the low half of an entry until its high half arrives,
// then emits a commit strobe with the assembled {high, low} word.
// Optional macro HALF_FLUSH_EN adds a flush input that commits a lone low
// half zero-extended when no push is present and the FIFO has room.
module pair_stage
  import pair_fifo_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_acc,
  input  logic [DW-1:0] write_data,
`ifdef HALF_FLUSH_EN
  input  logic          flush,
  input  logic          room,
`endif
  output logic          commit,
  output logic [2*DW-1:0] commit_data,
  output logic          half_pending
);

  stage_e        state_q, state_d;
  logic [DW-1:0] lo_q, lo_d;

  // Next-state, staging-register and commit decode.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    commit      = 1'b0;
    commit_data = {write_data, lo_q};
    case (state_q)
      ST_LOW: begin
        if (push_acc) begin
          lo_d    = write_data;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (push_acc) begin
          commit  = 1'b1;
          state_d = ST_LOW;
        end
`ifdef HALF_FLUSH_EN
        // A real push always wins; flush only closes out a lone low half.
        else if (flush && room) begin
          commit      = 1'b1;
          commit_data = {{DW{1'b0}}, lo_q};
          state_d     = ST_LOW;
        end
`endif
      end
      default: state_d = ST_LOW;
    endcase
  end

  // Staging state and low-half register; reset discards any pending half.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOW;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
    end
  end

  assign half_pending = (state_q == ST_HIGH);

endmodule

// File: rtl/pair_merge_fifo.sv
// pair_merge_fifo: assembles pairs of DW-bit pushes into 2*DW-bit entries
// stored in a DEPTH-entry circular buffer with first-word fall-through read.
// Optional macro HALF_FLUSH_EN adds the flush input (see pair_stage).
module pair_merge_fifo
  import pair_fifo_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   write_data,
  input  logic            push,
  output logic            full,
  output logic            half_pending,
  output logic [2*DW-1:0] read_data,
  output logic            empty,
`ifdef HALF_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            pop
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2*DW-1:0] mem_q [DEPTH];
  logic [2*DW-1:0] mem_d [DEPTH];

  logic            push_acc, pop_acc;
  logic            commit;
  logic [2*DW-1:0] commit_data;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_MAX);
  assign pop_acc  = pop && !empty;
  // A push while full is taken only when a same-cycle pop frees a slot.
  assign push_acc = push && (!full || pop);

  pair_stage #(.DW(DW)) u_stage (
    .clk          (clk),
    .rst          (rst),
    .push_acc     (push_acc),
    .write_data   (write_data),
`ifdef HALF_FLUSH_EN
    .flush        (flush),
    .room         (!full || pop_acc),
`endif
    .commit       (commit),
    .commit_data  (commit_data),
    .half_pending (half_pending)
  );

  // Pointer, counter and memory next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];

    if (commit) begin
      mem_d[tail_q] = commit_data;
      tail_d        = (tail_q == LAST) ? '0 : tail_q + 1'b1;
    end
    if (pop_acc) begin
      head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
    end
    if (commit && !pop_acc) begin
      count_d = count_q + 1'b1;
    end else if (pop_acc && !commit) begin
      count_d = count_q - 1'b1;
    end
  end

  // Buffer state registers; reset clears pointers, count and storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign read_data = mem_q[head_q];

endmodule
